// File: rtl/fpga_uplink_pkg.sv
// fpga_uplink_pkg: shared message codes, field positions and message builder for the status uplink
package fpga_uplink_pkg;
  localparam logic [7:0] MSG_HB = 8'h00;
  localparam logic [7:0] MSG_CHG = 8'h80;
  localparam logic [7:0] MSG_EVT_BASE = 8'h01;
  localparam int TYPE_LSB = 56;
  localparam int SEQ_LSB = 48;
  localparam int OVF_BIT = 40;
  localparam int BODY_W = 40;
  typedef enum logic [1:0] {SRC_NONE, SRC_EVT, SRC_CHG, SRC_HB} src_e;
  function automatic logic [63:0] mk_msg(input logic [7:0] typ, input logic [7:0] seq,
                                         input logic ovf, input logic [BODY_W-1:0] body);
    logic [63:0] m;
    m = '0;
    m[TYPE_LSB +: 8] = typ;
    m[SEQ_LSB +: 8] = seq;
    m[OVF_BIT] = ovf;
    m[BODY_W-1:0] = body;
    return m;
  endfunction
endpackage

// File: rtl/uplink_rr_arbiter.sv
// uplink_rr_arbiter: round-robin one-hot grant among N requesters, search starting at ptr
module uplink_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
)(
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);
  logic [IW-1:0] c;
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c = ptr;
    for (int i = 0; i < N; i++) begin
      if (en && !vld && req[c]) begin
        gnt[c] = 1'b1;
        idx = c;
        vld = 1'b1;
      end
      c = (c == IW'(N - 1)) ? '0 : c + 1'b1;
    end
  end
endmodule

// File: rtl/fpga_status_uplink.sv
// fpga_status_uplink: merges heartbeat, rate-limited status-change and buffered event
// messages onto one registered 64-bit valid/ready uplink port
module fpga_status_uplink
  import fpga_uplink_pkg::*;
#(
  parameter int CLK_PER_MS = 100000,
  parameter int HB_PERIOD_MS = 500,
  parameter int MIN_GAP_MS = 10,
  parameter int STATUS_W = 35,
  parameter int EVT_NUM = 4,
  parameter int EVT_W = 8
)(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [STATUS_W-1:0]      status_i,
  input  logic                     chg_report_en_i,
  input  logic                     heartbeat_bypass_i,
  input  logic [EVT_NUM-1:0]       evt_valid_i,
  input  logic [EVT_NUM*EVT_W-1:0] evt_data_i,
  output logic [63:0]              msg_data_o,
  output logic                     msg_valid_o,
  input  logic                     msg_ready_i,
  output logic [7:0]               hb_miss_cnt_o
);
  localparam int MSW = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;
  localparam int IW = EVT_NUM > 1 ? $clog2(EVT_NUM) : 1;
  logic [MSW-1:0] ms_cnt_q, ms_cnt_d;
  logic [9:0] hb_cnt_q, hb_cnt_d;
  logic [7:0] gap_q, gap_d, hb_seq_q, hb_seq_d, miss_q, miss_d;
  logic hb_pend_q, hb_pend_d, chg_pend_q, chg_pend_d, msg_valid_q, msg_valid_d;
  logic [STATUS_W-1:0] status_prev_q;
  logic [EVT_NUM-1:0] evt_pend_q, evt_pend_d, evt_ovf_q, evt_ovf_d, evt_gnt;
  logic [EVT_W-1:0] evt_buf_q [EVT_NUM];
  logic [EVT_W-1:0] evt_buf_d [EVT_NUM];
  logic [IW-1:0] rr_q, rr_d, evt_idx;
  logic [63:0] msg_data_q, msg_data_d;
  logic ms_tick, hb_fire, hb_set, free, chg_elig, evt_any;
  src_e src;
  uplink_rr_arbiter #(.N(EVT_NUM)) u_arb (
    .en(free), .req(evt_pend_q), .ptr(rr_q), .gnt(evt_gnt), .idx(evt_idx), .vld(evt_any)
  );
  always_comb begin
    ms_tick = ms_cnt_q == MSW'(CLK_PER_MS - 1);
    hb_fire = ms_tick && hb_cnt_q == 10'(HB_PERIOD_MS - 1);
    ms_cnt_d = ms_tick ? '0 : ms_cnt_q + 1'b1;
    hb_cnt_d = hb_fire ? '0 : (ms_tick ? hb_cnt_q + 1'b1 : hb_cnt_q);
    free = !msg_valid_q || msg_ready_i;
    chg_elig = chg_pend_q && gap_q == '0;
    src = evt_any ? SRC_EVT : !free ? SRC_NONE : chg_elig ? SRC_CHG : hb_pend_q ? SRC_HB : SRC_NONE;
    hb_set = hb_fire && !heartbeat_bypass_i;
    hb_pend_d = hb_set || (hb_pend_q && src != SRC_HB);
    // a tick is lost only when the previous heartbeat is still waiting and not leaving now
    miss_d = (hb_set && hb_pend_q && src != SRC_HB && miss_q != 8'hff) ? miss_q + 1'b1 : miss_q;
    chg_pend_d = (status_i != status_prev_q && chg_report_en_i) || (chg_pend_q && src != SRC_CHG);
    gap_d = src == SRC_CHG ? 8'(MIN_GAP_MS) : (ms_tick && gap_q != '0 ? gap_q - 1'b1 : gap_q);
    rr_d = evt_any ? (evt_idx == IW'(EVT_NUM - 1) ? '0 : evt_idx + 1'b1) : rr_q;
    hb_seq_d = src == SRC_HB ? hb_seq_q + 1'b1 : hb_seq_q;
    evt_pend_d = evt_valid_i | (evt_pend_q & ~evt_gnt);
    evt_ovf_d = (evt_valid_i & evt_pend_q & ~evt_gnt) | (~evt_valid_i & evt_ovf_q & ~evt_gnt);
    for (int c = 0; c < EVT_NUM; c++)
      evt_buf_d[c] = evt_valid_i[c] ? evt_data_i[c*EVT_W +: EVT_W] : evt_buf_q[c];
    msg_valid_d = free ? src != SRC_NONE : msg_valid_q;
    msg_data_d = src == SRC_EVT ? mk_msg(MSG_EVT_BASE + 8'(evt_idx), 8'h00, evt_ovf_q[evt_idx],
                                         BODY_W'(evt_buf_q[evt_idx]))
               : src == SRC_CHG ? mk_msg(MSG_CHG, 8'h00, 1'b0, BODY_W'(status_i))
               : src == SRC_HB ? mk_msg(MSG_HB, hb_seq_q, 1'b0, BODY_W'(status_i))
               : msg_data_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ms_cnt_q <= '0;
      hb_cnt_q <= '0;
      gap_q <= '0;
      hb_seq_q <= '0;
      miss_q <= '0;
      hb_pend_q <= 1'b0;
      chg_pend_q <= 1'b0;
      msg_valid_q <= 1'b0;
      msg_data_q <= '0;
      status_prev_q <= status_i;
      evt_pend_q <= '0;
      evt_ovf_q <= '0;
      evt_buf_q <= '{default: '0};
      rr_q <= '0;
    end else begin
      ms_cnt_q <= ms_cnt_d;
      hb_cnt_q <= hb_cnt_d;
      gap_q <= gap_d;
      hb_seq_q <= hb_seq_d;
      miss_q <= miss_d;
      hb_pend_q <= hb_pend_d;
      chg_pend_q <= chg_pend_d;
      msg_valid_q <= msg_valid_d;
      msg_data_q <= msg_data_d;
      status_prev_q <= status_i;
      evt_pend_q <= evt_pend_d;
      evt_ovf_q <= evt_ovf_d;
      evt_buf_q <= evt_buf_d;
      rr_q <= rr_d;
    end
  end
  assign msg_data_o = msg_data_q;
  assign msg_valid_o = msg_valid_q;
  assign hb_miss_cnt_o = miss_q;
endmodule
